// File: rtl/mips_regfile.sv
// MIPS general-purpose register file: two combinational read ports, one
// synchronous write port, register 0 hardwired to zero, async active-low reset.
module mips_regfile #(
    parameter  int unsigned WORD = 32,
    parameter  int unsigned SIZE = 32,
    localparam int unsigned BITS = $clog2(SIZE)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            write,
    input  logic [BITS-1:0] address_A,
    input  logic [BITS-1:0] address_B,
    input  logic [BITS-1:0] address_dest,
    input  logic [WORD-1:0] write_data,
    output logic [WORD-1:0] A,
    output logic [WORD-1:0] B
);

    logic [WORD-1:0] r_regs [SIZE];
    logic            w_wr_en;

    assign w_wr_en = reset && write && (address_dest != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_regs <= '{default: '0};
        end else if (w_wr_en) begin
            r_regs[address_dest] <= write_data;
        end
    end

    // Same-cycle writeback is forwarded so decode sees it without a bubble.
    always_comb begin
        A = '0;
        B = '0;
        if (reset) begin
            if (address_A != '0) begin
                A = (w_wr_en && (address_dest == address_A)) ? write_data : r_regs[address_A];
            end
            if (address_B != '0) begin
                B = (w_wr_en && (address_dest == address_B)) ? write_data : r_regs[address_B];
            end
        end
    end

endmodule

// File: tb/tb_mips_regfile.sv
// Directed self-checking bench for mips_regfile.
module tb_mips_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        write;
    logic [4:0]  address_A;
    logic [4:0]  address_B;
    logic [4:0]  address_dest;
    logic [31:0] write_data;
    logic [31:0] A;
    logic [31:0] B;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    mips_regfile #(.WORD(32), .SIZE(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .write        (write),
        .address_A    (address_A),
        .address_B    (address_B),
        .address_dest (address_dest),
        .write_data   (write_data),
        .A            (A),
        .B            (B)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_val;

        reset        = 1'b0;
        write        = 1'b0;
        address_A    = '0;
        address_B    = '0;
        address_dest = '0;
        write_data   = '0;

        // Reset held for two cycles; a write attempt during reset must be ignored.
        @(negedge clk);
        write        = 1'b1;
        address_dest = 5'd5;
        write_data   = 32'h0000_00AA;
        @(negedge clk);
        address_A = 5'd5;
        address_B = 5'd31;
        #1;
        check_eq("rst_A", A, 32'h0);
        check_eq("rst_B", B, 32'h0);
        write = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("rst_wr_ignored", A, 32'h0);

        // Write i+10 to reg i for i<20, write disabled for the rest.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            address_dest = 5'(i);
            write_data   = 32'(i + 10);
            write        = (i < 20);
        end
        @(negedge clk);
        write = 1'b0;
        for (int i = 0; i < 32; i++) begin
            address_A = 5'(i);
            address_B = 5'(31 - i);
            #1;
            exp_val = (i >= 1 && i < 20) ? 32'(i + 10) : 32'h0;
            check_eq($sformatf("rdA_r%0d", i), A, exp_val);
            exp_val = ((31 - i) >= 1 && (31 - i) < 20) ? 32'(31 - i + 10) : 32'h0;
            check_eq($sformatf("rdB_r%0d", 31 - i), B, exp_val);
        end

        address_A = 5'd24;
        address_B = 5'd21;
        #1;
        check_eq("unwritten_A24", A, 32'h0);
        check_eq("unwritten_B21", B, 32'h0);
        address_A = 5'd7;
        address_B = 5'd19;
        #1;
        check_eq("rd_A7", A, 32'd17);
        check_eq("rd_B19", B, 32'd29);

        // Forwarding: port A sees write_data before the edge, port B unaffected.
        @(negedge clk);
        write        = 1'b1;
        address_dest = 5'd9;
        write_data   = 32'hDEAD_BEEF;
        address_A    = 5'd9;
        address_B    = 5'd8;
        #1;
        check_eq("fwd_A_pre", A, 32'hDEAD_BEEF);
        check_eq("fwd_B_other", B, 32'd18);
        @(posedge clk);
        #1;
        write = 1'b0;
        #1;
        check_eq("fwd_A_post", A, 32'hDEAD_BEEF);

        // No forwarding when write is low.
        @(negedge clk);
        address_dest = 5'd10;
        write_data   = 32'h0000_0123;
        address_A    = 5'd10;
        #1;
        check_eq("nofwd_wr0", A, 32'd20);
        @(posedge clk);
        #1;
        check_eq("nowr_hold", A, 32'd20);

        // Register 0 stays zero, including the forwarding path.
        @(negedge clk);
        write        = 1'b1;
        address_dest = 5'd0;
        write_data   = 32'hFFFF_FFFF;
        address_A    = 5'd0;
        address_B    = 5'd0;
        #1;
        check_eq("r0_fwd_A", A, 32'h0);
        check_eq("r0_fwd_B", B, 32'h0);
        @(posedge clk);
        #1;
        write = 1'b0;
        #1;
        check_eq("r0_post", A, 32'h0);

        // Mid-cycle async reset with a pending write to reg7.
        @(negedge clk);
        address_A    = 5'd7;
        address_B    = 5'd19;
        write        = 1'b1;
        address_dest = 5'd7;
        write_data   = 32'h0000_0055;
        #1;
        check_eq("pre_rst_fwd", A, 32'h0000_0055);
        #1;
        reset = 1'b0;
        #1;
        check_eq("async_rst_A", A, 32'h0);
        check_eq("async_rst_B", B, 32'h0);
        @(posedge clk);
        @(negedge clk);
        write = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("post_rst_r7", A, 32'h0);
        check_eq("post_rst_r19", B, 32'h0);

        // First rising edge after release accepts a write.
        write        = 1'b1;
        address_dest = 5'd3;
        write_data   = 32'h0000_0077;
        address_A    = 5'd3;
        @(posedge clk);
        #1;
        write = 1'b0;
        #1;
        check_eq("first_wr_after_rst", A, 32'h0000_0077);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
